overdrive_scheduler: RTL and testbench

OVERDRIVE_SCHEDULER -- requirements
Module: overdrive_scheduler

---
 rtl/overdrive_scheduler_pkg.sv | 33 +++
 rtl/overdrive_scheduler_fixed_mul.sv | 24 ++
 rtl/overdrive_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_overdrive_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/overdrive_scheduler_pkg.sv
// Shared definitions for the overdrive scheduler: Q-format constants,
// FSM state encoding and the q_mul reference function.
// Optional feature macro: OVERDRIVE_GAIN_EN (adds the GAIN state).
package overdrive_pkg;

  localparam int     FRAC_BITS = 12;
  localparam longint ONE       = 64'sd1 <<< FRAC_BITS;

`ifdef OVERDRIVE_GAIN_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GAIN = 3'd1,
    ST_SQ   = 3'd2,
    ST_CUBE = 3'd3,
    ST_SUM  = 3'd4,
    ST_DONE = 3'd5
  } od_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQ   = 3'd2,
    ST_CUBE = 3'd3,
    ST_SUM  = 3'd4,
    ST_DONE = 3'd5
  } od_state_e;
`endif

  // Q-format multiply, full-width product, division truncating toward zero.
  function automatic longint q_mul(input longint a, input longint b);
    return (a * b) / ONE;
  endfunction

endpackage

// File: rtl/overdrive_scheduler_fixed_mul.sv
// Signed Q-format combinational multiplier: (a*b)/2**FRAC_BITS with the
// quotient truncated toward zero (negative products are biased before the
// arithmetic shift so the shift rounds toward zero instead of -inf).
module fixed_mul #(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 12
) (
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_p
);

  localparam logic signed [2*DATA_W-1:0] BIAS  =
    {{(2*DATA_W-FRAC_BITS){1'b0}}, {FRAC_BITS{1'b1}}};
  localparam logic signed [2*DATA_W-1:0] ZERO2 = '0;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [2*DATA_W-1:0] w_adj;

  assign w_prod = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
  assign w_adj  = w_prod + (w_prod[2*DATA_W-1] ? BIAS : ZERO2);
  assign o_p    = DATA_W'(w_adj >>> FRAC_BITS);

endmodule

// File: rtl/overdrive_scheduler.sv
// Two-channel soft-clip overdrive sharing one Q-format multiplier.
// y = clamp(x) or (x^3 + 3x)/4 with round-robin channel arbitration.
// Optional feature macro: OVERDRIVE_GAIN_EN (i_gain port + GAIN state).
module overdrive_scheduler #(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [1:0]             i_valid,
  input  logic [1:0][DATA_W-1:0] i_sample,
  output logic [1:0]             o_ready,
  output logic                   o_valid,
  output logic [DATA_W-1:0]      o_sample,
  output logic                   o_chan,
  input  logic                   i_ready
`ifdef OVERDRIVE_GAIN_EN
  ,input logic signed [DATA_W-1:0] i_gain
`endif
);

  import overdrive_pkg::*;

  localparam logic [2:0] S_IDLE = ST_IDLE;
`ifdef OVERDRIVE_GAIN_EN
  localparam logic [2:0] S_GAIN = ST_GAIN;
`endif
  localparam logic [2:0] S_SQ   = ST_SQ;
  localparam logic [2:0] S_CUBE = ST_CUBE;
  localparam logic [2:0] S_SUM  = ST_SUM;
  localparam logic [2:0] S_DONE = ST_DONE;

  localparam logic signed [DATA_W-1:0] Q_ONE    =
    {{(DATA_W-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
  localparam logic signed [DATA_W-1:0] HALF     = Q_ONE >>> 1;
  localparam logic signed [DATA_W-1:0] NEG_ONE  = -Q_ONE;
  localparam logic signed [DATA_W-1:0] NEG_HALF = -HALF;
  localparam logic signed [DATA_W-1:0] THREE    = {{(DATA_W-2){1'b0}}, 2'b11};
  localparam logic signed [DATA_W-1:0] ZERO     = '0;

  logic [2:0]               r_state;
  logic                     r_last;
  logic                     r_chan;
  logic signed [DATA_W-1:0] r_x;
  logic signed [DATA_W-1:0] r_sq;
  logic signed [DATA_W-1:0] r_cube;
  logic                     r_valid;
  logic [DATA_W-1:0]        r_sample;
  logic                     r_ochan;
`ifdef OVERDRIVE_GAIN_EN
  logic signed [DATA_W-1:0] r_gain;
`endif

  logic [1:0]               w_grant;
  logic                     w_grant_ch;
  logic                     w_hs;
  logic signed [DATA_W-1:0] w_ma;
  logic signed [DATA_W-1:0] w_mb;
  logic signed [DATA_W-1:0] w_mp;
  logic signed [DATA_W-1:0] w_poly;
  logic signed [DATA_W-1:0] w_quart;
  logic signed [DATA_W-1:0] w_result;

  // Round-robin grant: only in IDLE and never during reset; ties go to the
  // channel that was not served last.
  always_comb begin
    w_grant    = 2'b00;
    w_grant_ch = 1'b0;
    if ((r_state == S_IDLE) && !i_rst) begin
      case (i_valid)
        2'b01:   begin w_grant = 2'b01; w_grant_ch = 1'b0; end
        2'b10:   begin w_grant = 2'b10; w_grant_ch = 1'b1; end
        2'b11: begin
          if (r_last) begin
            w_grant = 2'b01; w_grant_ch = 1'b0;
          end else begin
            w_grant = 2'b10; w_grant_ch = 1'b1;
          end
        end
        default: begin w_grant = 2'b00; w_grant_ch = 1'b0; end
      endcase
    end else begin
      w_grant    = 2'b00;
      w_grant_ch = 1'b0;
    end
  end

  assign w_hs    = |w_grant;
  assign o_ready = w_grant;

  // Operand steering for the single shared multiplier.
  always_comb begin
    w_ma = r_x;
    w_mb = r_x;
    case (r_state)
`ifdef OVERDRIVE_GAIN_EN
      S_GAIN:  begin w_ma = r_x;  w_mb = r_gain; end
`endif
      S_CUBE:  begin w_ma = r_sq; w_mb = r_x;    end
      default: begin w_ma = r_x;  w_mb = r_x;    end
    endcase
  end

  fixed_mul #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS)) u_mul (
    .i_a (w_ma),
    .i_b (w_mb),
    .o_p (w_mp)
  );

  // Polynomial (x^3 + 3x)/4 with toward-zero division, then clamp on x.
  always_comb begin
    w_poly  = r_cube + (r_x <<< 1) + r_x;
    w_quart = (w_poly + (w_poly[DATA_W-1] ? THREE : ZERO)) >>> 2;
    if (r_x >= Q_ONE) begin
      w_result = HALF;
    end else if (r_x <= NEG_ONE) begin
      w_result = NEG_HALF;
    end else begin
      w_result = w_quart;
    end
  end

  // Sequencer: accept, (gain), square, cube, sum, then hold result until taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_chan   <= 1'b0;
      r_x      <= '0;
      r_sq     <= '0;
      r_cube   <= '0;
      r_valid  <= 1'b0;
      r_sample <= '0;
      r_ochan  <= 1'b0;
`ifdef OVERDRIVE_GAIN_EN
      r_gain   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_x    <= i_sample[w_grant_ch];
            r_chan <= w_grant_ch;
            r_last <= w_grant_ch;
`ifdef OVERDRIVE_GAIN_EN
            r_gain  <= i_gain;
            r_state <= S_GAIN;
`else
            r_state <= S_SQ;
`endif
          end
        end
`ifdef OVERDRIVE_GAIN_EN
        S_GAIN: begin
          r_x     <= w_mp;
          r_state <= S_SQ;
        end
`endif
        S_SQ: begin
          r_sq    <= w_mp;
          r_state <= S_CUBE;
        end
        S_CUBE: begin
          r_cube  <= w_mp;
          r_state <= S_SUM;
        end
        S_SUM: begin
          r_sample <= w_result;
          r_ochan  <= r_chan;
          r_valid  <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_valid  = r_valid;
  assign o_sample = r_sample;
  assign o_chan   = r_ochan;

endmodule

// File: tb/tb_overdrive_scheduler.sv
// Self-checking bench for overdrive_scheduler (works with and without
// OVERDRIVE_GAIN_EN).
module tb_overdrive_scheduler;

  localparam int     DW     = 32;
  localparam longint ONE_TB = 64'sd4096;
`ifdef OVERDRIVE_GAIN_EN
  localparam int LAT     = 5;
  localparam bit GAIN_ON = 1'b1;
`else
  localparam int LAT     = 4;
  localparam bit GAIN_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         i_valid;
  logic [1:0][DW-1:0] i_sample;
  logic [1:0]         o_ready;
  logic               o_valid;
  logic [DW-1:0]      o_sample;
  logic               o_chan;
  logic               i_ready;
  logic signed [DW-1:0] i_gain;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  overdrive_scheduler #(.DATA_W(DW), .FRAC_BITS(12)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .i_sample (i_sample),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_sample (o_sample),
    .o_chan   (o_chan),
    .i_ready  (i_ready)
`ifdef OVERDRIVE_GAIN_EN
    ,.i_gain  (i_gain)
`endif
  );

  function automatic longint qm(input longint a, input longint b);
    return (a * b) / ONE_TB;
  endfunction

  // Reference: soft clip computed straight from the transfer rule.
  function automatic longint model(input longint s, input longint g);
    longint x;
    x = GAIN_ON ? qm(s, g) : s;
    if (x >= ONE_TB)  return ONE_TB / 2;
    if (x <= -ONE_TB) return -(ONE_TB / 2);
    return (qm(qm(x, x), x) + 3 * x) / 4;
  endfunction

  task automatic wait_grant(input int ch, input logic signed [DW-1:0] s,
                            input logic signed [DW-1:0] g);
    int n;
    @(negedge clk);
    i_valid[ch]  = 1'b1;
    i_sample[ch] = s;
    i_gain       = g;
    #1;
    n = 0;
    while (o_ready[ch] !== 1'b1 && n < 60) begin
      @(negedge clk); #1; n++;
    end
    tests++;
    if (o_ready[ch] !== 1'b1) begin
      fails++;
      $display("FAIL grant_timeout ch%0d: o_ready=%b, required bit %0d set", ch, o_ready, ch);
    end
    @(posedge clk);
  endtask

  task automatic collect(input int ch, input longint e);
    int lat;
    logic signed [DW-1:0] ev;
    ev  = e[DW-1:0];
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        tests++;
        if (o_ready !== 2'b00) begin
          fails++;
          $display("FAIL ready_pulse: o_ready=%b one cycle after handshake, required 00", o_ready);
        end
        i_valid[ch] = 1'b0;
      end
    end while (o_valid !== 1'b1 && lat < 20);
    tests++;
    if (lat != LAT) begin
      fails++;
      $display("FAIL latency: got %0d cycles, required %0d", lat, LAT);
    end
    tests++;
    if (o_sample !== ev) begin
      fails++;
      $display("FAIL sample: got %0d, required %0d", $signed(o_sample), ev);
    end
    tests++;
    if (o_chan !== ch[0]) begin
      fails++;
      $display("FAIL chan: got %0d, required %0d", o_chan, ch);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; i_valid = 2'b11; #1;
    tests++;
    if (o_ready !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b, required 00", o_ready);
    end
    @(negedge clk);
    tests++;
    if (o_valid !== 1'b0 || o_sample !== '0 || o_chan !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b sample=%0d chan=%b, required 0/0/0", o_valid, o_sample, o_chan);
    end
    rst = 1'b0; #1;
    tests++;
    if (o_ready !== 2'b01) begin
      fails++; $display("FAIL first_tie: got %b, required 01", o_ready);
    end
    i_valid = 2'b00;
  endtask

  task automatic test_directed();
    int     ch_t[9]  = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    longint x_t[9]   = '{2048, 3000, -2048, 1, 4096, -5000, 4095, -4095, -4096};
    longint e_t[9]   = '{1664, 2652, -1664, 0, 2048, -2048, 0, 0, -2048};
    for (int i = 0; i < 9; i++) begin
      longint e;
      e = (i < 6 || i == 8) ? e_t[i] : model(x_t[i], 4096);
      wait_grant(ch_t[i], x_t[i][DW-1:0], 32'sd4096);
      collect(ch_t[i], e);
    end
  endtask

  task automatic test_gain();
`ifdef OVERDRIVE_GAIN_EN
    wait_grant(0, 32'sd1024, 32'sd8192);
    collect(0, 1664);
    wait_grant(1, 32'sd3000, -32'sd4096);
    collect(1, -2652);
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int     ch;
      longint s, g;
      ch = int'($urandom_range(0, 1));
      s  = longint'($urandom_range(0, 12000)) - 6000;
      g  = longint'($urandom_range(0, 12288)) - 4096;
      wait_grant(ch, s[DW-1:0], g[DW-1:0]);
      collect(ch, model(s, g));
    end
  endtask

  task automatic test_round_robin();
    int     got  = 0;
    int     n    = 0;
    logic   prev = 1'b0;
    logic   chans[4];
    logic [DW-1:0] samps[4];
    do_reset();
    i_sample[0] = 32'sd2048;
    i_sample[1] = -32'sd2048;
    i_gain      = 32'sd4096;
    i_valid     = 2'b11;
    while (got < 4 && n < 100) begin
      #1;
      tests++;
      if (o_ready == 2'b11 || (prev && o_ready != 2'b00)) begin
        fails++; $display("FAIL rr_pulse: o_ready=%b prev_active=%b", o_ready, prev);
      end
      prev = (o_ready != 2'b00);
      if (o_valid === 1'b1) begin
        chans[got] = o_chan; samps[got] = o_sample; got++;
      end
      @(negedge clk); n++;
    end
    i_valid = 2'b00;
    tests++;
    if (got != 4) begin
      fails++; $display("FAIL rr_count: got %0d results, required 4", got);
    end
    for (int k = 0; k < got; k++) begin
      logic signed [DW-1:0] ex;
      ex = (k % 2 == 0) ? 32'sd1664 : -32'sd1664;
      tests++;
      if (chans[k] !== k[0] || samps[k] !== ex) begin
        fails++;
        $display("FAIL rr_order[%0d]: chan=%b sample=%0d, required chan=%0d sample=%0d", k, chans[k], $signed(samps[k]), k % 2, ex);
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0;
    wait_grant(1, 32'sd3000, 32'sd4096);
    collect(1, 2652);
    i_valid[0]  = 1'b1;
    i_sample[0] = -32'sd2048;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      tests++;
      if (o_valid !== 1'b1 || $signed(o_sample) !== 32'sd2652 || o_chan !== 1'b1 || o_ready !== 2'b00) begin
        fails++;
        $display("FAIL hold[%0d]: valid=%b sample=%0d chan=%b ready=%b, required 1/2652/1/00", c, o_valid, $signed(o_sample), o_chan, o_ready);
      end
    end
    i_ready = 1'b1;
    wait_grant(0, -32'sd2048, 32'sd4096);
    collect(0, -1664);
  endtask

  task automatic test_reset_midop();
    wait_grant(0, 32'sd2048, 32'sd4096);
    repeat (LAT - 3) @(posedge clk);
    @(negedge clk);
    i_valid = 2'b10;
    rst     = 1'b1; #1;
    tests++;
    if (o_ready !== 2'b00) begin
      fails++; $display("FAIL midop_ready: got %b during reset, required 00", o_ready);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    tests++;
    if (o_valid !== 1'b0 || o_sample !== '0 || o_ready !== 2'b10) begin
      fails++;
      $display("FAIL midop_idle: valid=%b sample=%0d ready=%b, required 0/0/10", o_valid, o_sample, o_ready);
    end
    i_valid = 2'b00;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if (o_valid !== 1'b0) begin
        fails++; $display("FAIL midop_discard[%0d]: o_valid=%b, required 0", c, o_valid);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    i_valid  = 2'b00;
    i_sample = '0;
    i_ready  = 1'b1;
    i_gain   = 32'sd4096;
    repeat (2) @(posedge clk);
    test_reset();
    test_directed();
    test_gain();
    test_round_robin();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
